// File: rtl/decode_stage_pkg.sv
// Shared widths, opcode map and decoded-control payload for the decode stage.
package decode_stage_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned REG_W     = $clog2(NUM_REGS);
  localparam int unsigned OP_W      = 4;
  localparam int unsigned FUNC_W    = 6;
  localparam int unsigned IMM8_W    = 8;

  localparam logic [OP_W-1:0] OP_BNE   = 4'd0;
  localparam logic [OP_W-1:0] OP_BEQ   = 4'd1;
  localparam logic [OP_W-1:0] OP_BGZ   = 4'd2;
  localparam logic [OP_W-1:0] OP_BLZ   = 4'd3;
  localparam logic [OP_W-1:0] OP_ADI   = 4'd4;
  localparam logic [OP_W-1:0] OP_ORI   = 4'd5;
  localparam logic [OP_W-1:0] OP_LHI   = 4'd6;
  localparam logic [OP_W-1:0] OP_LWD   = 4'd7;
  localparam logic [OP_W-1:0] OP_SWD   = 4'd8;
  localparam logic [OP_W-1:0] OP_JMP   = 4'd9;
  localparam logic [OP_W-1:0] OP_JAL   = 4'd10;
  localparam logic [OP_W-1:0] OP_RTYPE = 4'd15;

  localparam logic [REG_W-1:0] LINK_REG = REG_W'(2);

  typedef struct packed {
    logic                 use_rs;
    logic                 use_rt;
    logic [REG_W-1:0]     write_reg;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic [WORD_SIZE-1:0] imm;
  } dec_t;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// Combinational opcode decoder: source usage, destination, memory control and immediate.
module decode_stage_instr_decoder
  import decode_stage_pkg::*;
(
  input  logic [WORD_SIZE-1:0] instr,
  output dec_t                 dec_c
);

  logic [OP_W-1:0]   opcode;
  logic [REG_W-1:0]  rt;
  logic [REG_W-1:0]  rd;
  logic [IMM8_W-1:0] imm8;

  assign opcode = instr[15:12];
  assign rt     = instr[9:8];
  assign rd     = instr[7:6];
  assign imm8   = instr[7:0];

  always_comb begin
    dec_c     = '0;
    dec_c.imm = {{(WORD_SIZE-IMM8_W){imm8[IMM8_W-1]}}, imm8};
    case (opcode)
      OP_RTYPE: begin
        dec_c.use_rs    = 1'b1;
        dec_c.use_rt    = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.write_reg = rd;
      end
      OP_BNE, OP_BEQ: begin
        dec_c.use_rs = 1'b1;
        dec_c.use_rt = 1'b1;
      end
      OP_BGZ, OP_BLZ: dec_c.use_rs = 1'b1;
      OP_ADI: begin
        dec_c.use_rs    = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.write_reg = rt;
      end
      OP_ORI: begin
        dec_c.use_rs    = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.write_reg = rt;
        dec_c.imm       = {{(WORD_SIZE-IMM8_W){1'b0}}, imm8};
      end
      OP_LHI: begin
        dec_c.reg_write = 1'b1;
        dec_c.write_reg = rt;
        dec_c.imm       = {imm8, {(WORD_SIZE-IMM8_W){1'b0}}};
      end
      OP_LWD: begin
        dec_c.use_rs    = 1'b1;
        dec_c.reg_write = 1'b1;
        dec_c.mem_read  = 1'b1;
        dec_c.write_reg = rt;
      end
      OP_SWD: begin
        dec_c.use_rs    = 1'b1;
        dec_c.use_rt    = 1'b1;
        dec_c.mem_write = 1'b1;
      end
      OP_JAL: begin
        dec_c.reg_write = 1'b1;
        dec_c.write_reg = LINK_REG;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register-file addressing, writeback bypass, load-use hazard and ID/EX register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_instr,
  input  logic [WORD_SIZE-1:0] if_pc,
  output logic                 id_ready,
  output logic [REG_W-1:0]     rf_read_reg1,
  output logic [REG_W-1:0]     rf_read_reg2,
  input  logic [WORD_SIZE-1:0] rf_read_data1,
  input  logic [WORD_SIZE-1:0] rf_read_data2,
  input  logic                 wb_reg_write,
  input  logic [REG_W-1:0]     wb_write_reg,
  input  logic [WORD_SIZE-1:0] wb_write_data,
  input  logic                 flush,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [OP_W-1:0]      ex_opcode,
  output logic [FUNC_W-1:0]    ex_func,
  output logic [WORD_SIZE-1:0] ex_op1,
  output logic [WORD_SIZE-1:0] ex_op2,
  output logic [WORD_SIZE-1:0] ex_imm,
  output logic [REG_W-1:0]     ex_write_reg,
  output logic                 ex_reg_write,
  output logic                 ex_mem_read,
  output logic                 ex_mem_write,
  output logic [WORD_SIZE-1:0] ex_pc,
  output logic [15:0]          stall_count
);

  dec_t                 dec;
  logic [REG_W-1:0]     rs;
  logic [REG_W-1:0]     rt;
  logic [WORD_SIZE-1:0] op1_c;
  logic [WORD_SIZE-1:0] op2_c;
  logic                 hazard_c;
  logic                 advance_c;

  // Source indices and usage of the instruction held in ID/EX, for in-place bypass while stalled.
  logic [REG_W-1:0]     cap_rs;
  logic [REG_W-1:0]     cap_rt;
  logic                 cap_use_rs;
  logic                 cap_use_rt;

  decode_stage_instr_decoder u_instr_decoder (
    .instr (if_instr),
    .dec_c (dec)
  );

  assign rs           = if_instr[11:10];
  assign rt           = if_instr[9:8];
  assign rf_read_reg1 = rs;
  assign rf_read_reg2 = rt;

  // Register file writes at the edge, so a same-cycle writeback must be forwarded here.
  assign op1_c = (wb_reg_write && (wb_write_reg == rs)) ? wb_write_data : rf_read_data1;
  assign op2_c = (wb_reg_write && (wb_write_reg == rt)) ? wb_write_data : rf_read_data2;

  assign hazard_c  = if_valid & ex_valid & ex_mem_read & ex_reg_write &
                     ((dec.use_rs & (ex_write_reg == rs)) | (dec.use_rt & (ex_write_reg == rt)));
  assign advance_c = ex_ready | ~ex_valid;
  assign id_ready  = advance_c & ~hazard_c & ~flush;

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      ex_valid     <= 1'b0;
      ex_opcode    <= '0;
      ex_func      <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_write_reg <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_pc        <= '0;
      cap_rs       <= '0;
      cap_rt       <= '0;
      cap_use_rs   <= 1'b0;
      cap_use_rt   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (advance_c && if_valid && !hazard_c) begin
      ex_valid     <= 1'b1;
      ex_opcode    <= if_instr[15:12];
      ex_func      <= if_instr[5:0];
      ex_op1       <= op1_c;
      ex_op2       <= op2_c;
      ex_imm       <= dec.imm;
      ex_write_reg <= dec.write_reg;
      ex_reg_write <= dec.reg_write;
      ex_mem_read  <= dec.mem_read;
      ex_mem_write <= dec.mem_write;
      ex_pc        <= if_pc;
      cap_rs       <= rs;
      cap_rt       <= rt;
      cap_use_rs   <= dec.use_rs;
      cap_use_rt   <= dec.use_rt;
    end else if (advance_c) begin
      ex_valid <= 1'b0;
    end else begin
      if (wb_reg_write && cap_use_rs && (wb_write_reg == cap_rs)) ex_op1 <= wb_write_data;
      if (wb_reg_write && cap_use_rt && (wb_write_reg == cap_rt)) ex_op2 <= wb_write_data;
    end
  end

  // Hazard-stall cycle counter, saturating; a flush in the same cycle cancels the stall.
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      stall_count <= '0;
    end else if (hazard_c && advance_c && !flush && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, bypass, load-use stall, hold, flush, async reset.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic                 clk;
  logic                 reset_n;
  logic                 if_valid;
  logic [WORD_SIZE-1:0] if_instr;
  logic [WORD_SIZE-1:0] if_pc;
  logic                 id_ready;
  logic [REG_W-1:0]     rf_read_reg1;
  logic [REG_W-1:0]     rf_read_reg2;
  logic [WORD_SIZE-1:0] rf_read_data1;
  logic [WORD_SIZE-1:0] rf_read_data2;
  logic                 wb_reg_write;
  logic [REG_W-1:0]     wb_write_reg;
  logic [WORD_SIZE-1:0] wb_write_data;
  logic                 flush;
  logic                 ex_ready;
  logic                 ex_valid;
  logic [OP_W-1:0]      ex_opcode;
  logic [FUNC_W-1:0]    ex_func;
  logic [WORD_SIZE-1:0] ex_op1;
  logic [WORD_SIZE-1:0] ex_op2;
  logic [WORD_SIZE-1:0] ex_imm;
  logic [REG_W-1:0]     ex_write_reg;
  logic                 ex_reg_write;
  logic                 ex_mem_read;
  logic                 ex_mem_write;
  logic [WORD_SIZE-1:0] ex_pc;
  logic [15:0]          stall_count;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .if_valid      (if_valid),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .id_ready      (id_ready),
    .rf_read_reg1  (rf_read_reg1),
    .rf_read_reg2  (rf_read_reg2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .ex_valid      (ex_valid),
    .ex_opcode     (ex_opcode),
    .ex_func       (ex_func),
    .ex_op1        (ex_op1),
    .ex_op2        (ex_op2),
    .ex_imm        (ex_imm),
    .ex_write_reg  (ex_write_reg),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_pc         (ex_pc),
    .stall_count   (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b1;
    if_valid      = 1'b0;
    if_instr      = '0;
    if_pc         = '0;
    rf_read_data1 = '0;
    rf_read_data2 = '0;
    wb_reg_write  = 1'b0;
    wb_write_reg  = '0;
    wb_write_data = '0;
    flush         = 1'b0;
    ex_ready      = 1'b1;
    #12;
    chk("rst_ex_valid", 16'(ex_valid), 16'd0);
    chk("rst_stall", stall_count, 16'd0);
    chk("rst_id_ready", 16'(id_ready), 16'd1);
    reset_n = 1'b0;
    #1;

    // ADI $1,$0,-3
    if_valid = 1'b1; if_instr = 16'h41FD; if_pc = 16'h0011;
    #1;
    chk("adi_rf_reg1", 16'(rf_read_reg1), 16'd0);
    chk("adi_rf_reg2", 16'(rf_read_reg2), 16'd1);
    tick();
    chk("adi_valid", 16'(ex_valid), 16'd1);
    chk("adi_imm", ex_imm, 16'hFFFD);
    chk("adi_wreg", 16'(ex_write_reg), 16'd1);
    chk("adi_regwr", 16'(ex_reg_write), 16'd1);
    chk("adi_opcode", 16'(ex_opcode), 16'd4);
    chk("adi_pc", ex_pc, 16'h0011);

    // LHI $3,0xAB
    if_instr = 16'h63AB;
    tick();
    chk("lhi_imm", ex_imm, 16'hAB00);
    chk("lhi_wreg", 16'(ex_write_reg), 16'd3);

    // JAL writes the link register
    if_instr = 16'hA005;
    tick();
    chk("jal_wreg", 16'(ex_write_reg), 16'd2);
    chk("jal_regwr", 16'(ex_reg_write), 16'd1);

    // LWD $2,$0,4 then ADD using $2 as rs: one bubble
    if_instr = 16'h7204;
    tick();
    chk("lwd_memrd", 16'(ex_mem_read), 16'd1);
    chk("lwd_wreg", 16'(ex_write_reg), 16'd2);
    if_instr = 16'hF9C0;
    #1;
    chk("lu_id_ready", 16'(id_ready), 16'd0);
    tick();
    chk("lu_bubble", 16'(ex_valid), 16'd0);
    chk("lu_stall", stall_count, 16'd1);
    chk("lu_id_ready2", 16'(id_ready), 16'd1);
    tick();
    chk("add_valid", 16'(ex_valid), 16'd1);
    chk("add_opcode", 16'(ex_opcode), 16'd15);
    chk("add_wreg", 16'(ex_write_reg), 16'd3);
    chk("add_stall", stall_count, 16'd1);

    // Same-cycle writeback bypass on rs
    if_instr = 16'h4710; rf_read_data1 = 16'h0000; rf_read_data2 = 16'h5555;
    wb_reg_write = 1'b1; wb_write_reg = 2'd1; wb_write_data = 16'h1234;
    tick();
    chk("byp_op1", ex_op1, 16'h1234);
    chk("byp_op2", ex_op2, 16'h5555);
    chk("byp_imm", ex_imm, 16'h0010);
    wb_reg_write = 1'b0;

    // SWD loaded, then held for three cycles with a WB to its rt
    if_instr = 16'h8102; rf_read_data1 = 16'h0A0A; rf_read_data2 = 16'h0B0B;
    tick();
    chk("swd_memwr", 16'(ex_mem_write), 16'd1);
    chk("swd_op2", ex_op2, 16'h0B0B);
    ex_ready = 1'b0; if_instr = 16'h5680;
    #1;
    chk("hold_id_ready", 16'(id_ready), 16'd0);
    tick();
    chk("hold1_opcode", 16'(ex_opcode), 16'd8);
    chk("hold1_op2", ex_op2, 16'h0B0B);
    wb_reg_write = 1'b1; wb_write_reg = 2'd1; wb_write_data = 16'hBEEF;
    tick();
    chk("hold2_op2", ex_op2, 16'hBEEF);
    chk("hold2_op1", ex_op1, 16'h0A0A);
    wb_reg_write = 1'b0;
    tick();
    chk("hold3_valid", 16'(ex_valid), 16'd1);
    chk("hold3_op2", ex_op2, 16'hBEEF);
    chk("hold3_imm", ex_imm, 16'h0002);
    ex_ready = 1'b1;
    #1;
    chk("release_id_ready", 16'(id_ready), 16'd1);
    tick();
    chk("ori_opcode", 16'(ex_opcode), 16'd5);
    chk("ori_imm", ex_imm, 16'h0080);
    chk("ori_wreg", 16'(ex_write_reg), 16'd2);
    chk("ori_op1", ex_op1, 16'h0A0A);

    // Flush together with a pending load-use hazard
    if_instr = 16'h7100;
    tick();
    chk("lwd2_valid", 16'(ex_valid), 16'd1);
    if_instr = 16'hF401; flush = 1'b1;
    #1;
    chk("flush_id_ready", 16'(id_ready), 16'd0);
    tick();
    chk("flush_valid", 16'(ex_valid), 16'd0);
    chk("flush_stall", stall_count, 16'd1);
    flush = 1'b0;
    tick();
    chk("post_flush_valid", 16'(ex_valid), 16'd1);
    chk("post_flush_func", 16'(ex_func), 16'd1);

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b1;
    #1;
    chk("arst_valid", 16'(ex_valid), 16'd0);
    chk("arst_stall", stall_count, 16'd0);
    chk("arst_opcode", 16'(ex_opcode), 16'd0);
    #1;
    reset_n = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage of the pipelined 16-bit CPU, sitting between fetch and execute.
- Accepts an instruction from fetch and drives the register-file read addresses.
- Combines register-file read data with a same-cycle writeback bypass, then registers the decoded fields and operands into the ID/EX pipeline register.
- Detects load-use hazards (inserts a bubble and stalls fetch), honours branch flush, and counts stall cycles.

Parameters:
- WORD_SIZE, 16, datapath width.
- NUM_REGS, 4, architectural registers.
- REG_W, 2, register index width (log2 NUM_REGS).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset, asynchronous, active-high.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  WORD_SIZE  instruction word.
- if_pc  in  WORD_SIZE  PC+1 of that instruction.
- id_ready  out  1  decode accepts the instruction this cycle.
- rf_read_reg1  out  REG_W  register-file read index 1 (rs).
- rf_read_reg2  out  REG_W  register-file read index 2 (rt).
- rf_read_data1  in  WORD_SIZE  combinational read data 1.
- rf_read_data2  in  WORD_SIZE  combinational read data 2.
- wb_reg_write  in  1  writeback commits this cycle.
- wb_write_reg  in  REG_W  writeback destination.
- wb_write_data  in  WORD_SIZE  writeback value.
- flush  in  1  taken branch/jump resolved in EX.
- ex_ready  in  1  execute accepts the ID/EX contents.
- ex_valid  out  1  ID/EX holds a valid instruction.
- ex_opcode  out  4  instr[15:12].
- ex_func  out  6  instr[5:0].
- ex_op1  out  WORD_SIZE  operand for rs.
- ex_op2  out  WORD_SIZE  operand for rt.
- ex_imm  out  WORD_SIZE  extended immediate.
- ex_write_reg  out  REG_W  destination register.
- ex_reg_write  out  1  instruction writes a register.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_pc  out  WORD_SIZE  PC+1 passed through.
- stall_count  out  16  saturating count of hazard-stall cycles.

Behaviour:
- Fields:
  - rs = instr[11:10], rt = instr[9:8], rd = instr[7:6], imm8 = instr[7:0].
  - rf_read_reg1 = rs and rf_read_reg2 = rt, combinational from if_instr.
- Decode by opcode:
  - 15: R-type; writes rd; uses rs, rt.
  - 0–3: branches; no write; uses rs; opcodes 0 and 1 also use rt.
  - 4 (ADI): writes rt; uses rs; imm sign-extended.
  - 5 (ORI): writes rt; uses rs; imm zero-extended.
  - 6 (LHI): writes rt; imm = {imm8, 8'h00}; no sources.
  - 7 (LWD): mem_read; writes rt; uses rs; imm sign-extended.
  - 8 (SWD): mem_write; uses rs, rt; imm sign-extended.
  - 9 (JMP): nothing written, nothing used.
  - 10 (JAL): writes register 2.
  - Other opcodes decode as NOP: reg_write, mem_read and mem_write all 0.
  - Immediate for opcodes without an explicit rule: sign-extended imm8.
- Writeback bypass (combinational):
  - The register file updates only at the clock edge, so same-cycle writeback must be bypassed.
  - op1 = wb_write_data if wb_reg_write and wb_write_reg == rs, else rf_read_data1; op2 likewise for rt.
- Hazard (combinational):
  - hazard = if_valid & ex_valid & ex_mem_read & ex_reg_write & ((use_rs & ex_write_reg == rs) | (use_rt & ex_write_reg == rt)).
- Control:
  - advance = ex_ready | ~ex_valid.
  - id_ready = advance & ~hazard & ~flush.
- Register update at posedge clk, in priority order:
  1. flush: ex_valid <= 0; the fetched instruction is discarded.
  2. advance & if_valid & ~hazard: load all ex_* from the decode; ex_valid <= 1.
  3. advance otherwise: ex_valid <= 0 (bubble); other ex_* may hold.
  4. ~advance (hold): ex_* hold, except held ex_op1/ex_op2 take wb_write_data when wb_reg_write matches the captured rs/rt and that source is used. Captured source indices and use flags are stored internally.
- stall_count: increments by 1 on each edge where hazard & advance & ~flush; saturates at 16'hFFFF.
- Latency: one cycle from acceptance (id_ready & if_valid) to ex_valid.
- Reset (reset_n high, asynchronous):
  - ex_valid = 0, and every ex_* field, stall_count and internal capture registers = 0.
  - id_ready follows its equation from the reset state.
  - Reset mid-operation drops any held instruction.
- Simultaneous events:
  - flush and hazard in the same cycle: flush wins and stall_count does not increment.
  - WB write to x and a decode reading x in the same cycle: the new value is captured.

Decomposition:
- Shared package/include holds WORD_SIZE, NUM_REGS, opcode constants (OP_RTYPE=15, OP_ADI=4, OP_ORI=5, OP_LHI=6, OP_LWD=7, OP_SWD=8, OP_JMP=9, OP_JAL=10, branch 0–3) and the JAL link register index (2).
- Sub-module instr_decoder: purely combinational; maps instr to use_rs, use_rt, write_reg, reg_write, mem_read, mem_write, imm.
- decode_stage keeps the bypass, hazard, pipeline register and counter.

Test Plan:
- Reset, then ADI $1,$0,-3 (16'h41FD) with if_valid=1 and ex_ready=1 → next cycle: ex_valid=1, ex_imm=16'hFFFD, ex_write_reg=1, ex_reg_write=1.
- LWD $2,$0,4 followed by R-type ADD using $2 as rs → one bubble cycle: id_ready=0, ex_valid=0 for the ADD slot, stall_count=1; the ADD then issues.
- wb_reg_write=1, wb_write_reg=1, wb_write_data=16'h1234 while decoding rs=1 with rf_read_data1=0 → ex_op1=16'h1234.
- ex_ready=0 for 3 cycles with ex_valid=1 → all ex_* stable and id_ready=0; a WB write to the captured rt during the hold updates ex_op2.
- flush=1 together with a pending hazard → ex_valid=0 next cycle, stall_count unchanged.
- reset_n pulsed high mid-stream between clock edges → ex_valid=0 and stall_count=0 immediately, without waiting for a clock edge.
